// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares a single uart_tx between four requesters. Each requester asks for a
//   contiguous message held in an asynchronous byte ROM. Requests are granted
//   round-robin. The winner's start address and length are latched. Its bytes
//   are then fetched from the ROM and loaded into uart_tx one at a time, using
//   the write_enable / TC handshake.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req[3:0]          per-channel request level (sampled only while idle)
//   req_addr          packed start addresses, channel i at [i*ADDR_W +: ADDR_W]
//   req_len           packed byte counts,     channel i at [i*LEN_W  +: LEN_W]
//   ack[3:0]          one-cycle pulse: channel i request latched
//   done[3:0]         one-cycle pulse: channel i message finished (or len 0)
//   busy              high whenever a message is in progress
//   grant_id          channel being served; holds last value when idle
//   rom_addr/rom_data registered ROM address, combinational ROM byte back
//   tx_data           registered byte presented to uart_tx
//   tx_write_enable   one-cycle load strobe to uart_tx
//   tx_TC             uart_tx idle / transmission complete
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [4*ADDR_W-1:0] req_addr,
    input  logic [4*LEN_W-1:0]  req_len,
    output logic [3:0]          ack,
    output logic [3:0]          done,
    output logic                busy,
    output logic [1:0]          grant_id,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [7:0]          rom_data,
    output logic [7:0]          tx_data,
    output logic                tx_write_enable,
    input  logic                tx_TC
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_GAP     = 3'd3,
        S_WAIT_TC = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          ack_q, ack_d;
    logic [3:0]          done_q, done_d;
    logic                busy_q, busy_d;
    logic [1:0]          grant_q, grant_d;
    logic [1:0]          last_q, last_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                we_q, we_d;
    logic [LEN_W-1:0]    rem_q, rem_d;

    logic [1:0]          win;
    logic [LEN_W-1:0]    win_len;

    // Round-robin pick: search starts just after the last grant and wraps.
    // Descending loop so the nearest candidate (smallest offset) wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        done_d     = '0;
        grant_d    = grant_q;
        last_d     = last_q;
        rom_addr_d = rom_addr_q;
        tx_data_d  = tx_data_q;
        we_d       = 1'b0;
        rem_d      = rem_q;
        win        = rr_pick(req, last_q);
        win_len    = req_len[win*LEN_W +: LEN_W];

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d      = win;
                    last_d       = win;
                    rom_addr_d   = req_addr[win*ADDR_W +: ADDR_W];
                    rem_d        = win_len;
                    ack_d[win]   = 1'b1;
                    // Zero-length message completes on the spot, no byte sent.
                    if (win_len == '0) done_d[win] = 1'b1;
                    else               state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                // Keep tracking the ROM until uart_tx is free to take it.
                tx_data_d = rom_data;
                if (tx_TC) begin
                    we_d    = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                rem_d      = rem_q - LEN_W'(1);
                state_d    = S_GAP;
            end
            // TC is stale here: uart_tx only drops it the cycle after the strobe.
            S_GAP: state_d = S_WAIT_TC;
            S_WAIT_TC: begin
                if (tx_TC) begin
                    if (rem_q == '0) begin
                        done_d[grant_q] = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ack_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
            last_q     <= 2'd3;
            rom_addr_q <= '0;
            tx_data_q  <= '0;
            we_q       <= 1'b0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            rom_addr_q <= rom_addr_d;
            tx_data_q  <= tx_data_d;
            we_q       <= we_d;
            rem_q      <= rem_d;
        end
    end

    assign ack             = ack_q;
    assign done            = done_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;
    assign rom_addr        = rom_addr_q;
    assign tx_data         = tx_data_q;
    assign tx_write_enable = we_q;

endmodule
